monitor_cmd_parser: RTL and testbench

MONITOR_CMD_PARSER -- requirements
Module: monitor_cmd_parser

---
 rtl/monitor_cmd_parser.sv | 171 +++++++++++++++++
 tb/tb_monitor_cmd_parser.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/monitor_cmd_parser.sv
// Byte-oriented command parser for a UART monitor port: decodes SOF/CMD/ADDR/DATA/CHK
// frames into single-cycle register read/write strobes and returns one ACK, NAK or read byte.
module monitor_cmd_parser #(
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  SOF_BYTE       = 8'h7E
) (
    input  logic       clk50,
    input  logic       reset_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_err,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic       busy,
    output logic [7:0] err_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        GET_ADDR,
        GET_DATA,
        GET_CHK,
        EXEC,
        RD_WAIT,
        RESP
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [TW-1:0]  timer;
    logic [7:0]     cmd_q;
    logic [7:0]     chk_q;
    logic           in_get;
    logic           byte_in;
    logic           timeout_hit;
    logic           chk_ok;
    logic           cmd_wr;
    logic           cmd_rd;
    logic           cnt_err;

    // tx handshake: tx_valid stays high with tx_data frozen until a cycle where
    // tx_ready is also high; that cycle is the transfer and the FSM then leaves RESP.
    assign tx_valid = (state == RESP);
    assign busy     = (state != IDLE);

    assign in_get  = (state == GET_CMD) || (state == GET_ADDR) ||
                     (state == GET_DATA) || (state == GET_CHK);
    // rx_err wins over a coincident rx_valid
    assign byte_in = rx_valid && !rx_err;

    assign timeout_hit = in_get && !rx_valid && !rx_err &&
                         (timer == TW'(TIMEOUT_CYCLES - 1));

    assign chk_ok = ((cmd_q ^ reg_addr ^ reg_wdata) == chk_q);
    assign cmd_wr = chk_ok && (cmd_q == CMD_WR);
    assign cmd_rd = chk_ok && (cmd_q == CMD_RD);

    always_comb begin
        state_next = state;
        reg_wr_en  = 1'b0;
        reg_rd_en  = 1'b0;
        cnt_err    = 1'b0;
        case (state)
            IDLE: begin
                if (byte_in && (rx_data == SOF_BYTE)) begin
                    state_next = GET_CMD;
                end
            end
            GET_CMD, GET_ADDR, GET_DATA, GET_CHK: begin
                if (rx_err) begin
                    state_next = IDLE;
                    cnt_err    = 1'b1;
                end else if (rx_valid) begin
                    case (state)
                        GET_CMD:  state_next = GET_ADDR;
                        GET_ADDR: state_next = GET_DATA;
                        GET_DATA: state_next = GET_CHK;
                        default:  state_next = EXEC;
                    endcase
                end else if (timeout_hit) begin
                    state_next = IDLE;
                    cnt_err    = 1'b1;
                end
            end
            EXEC: begin
                if (cmd_wr) begin
                    reg_wr_en  = 1'b1;
                    state_next = RESP;
                end else if (cmd_rd) begin
                    reg_rd_en  = 1'b1;
                    state_next = RD_WAIT;
                end else begin
                    cnt_err    = 1'b1;
                    state_next = RESP;
                end
            end
            RD_WAIT: begin
                state_next = RESP;
            end
            RESP: begin
                if (tx_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            state     <= IDLE;
            timer     <= '0;
            cmd_q     <= 8'h00;
            chk_q     <= 8'h00;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            tx_data   <= 8'h00;
            err_count <= 8'h00;
        end else begin
            state <= state_next;

            // counts idle cycles between bytes of a frame
            if (in_get && !rx_valid) begin
                timer <= timer + 1'b1;
            end else begin
                timer <= '0;
            end

            if (byte_in) begin
                case (state)
                    GET_CMD:  cmd_q     <= rx_data;
                    GET_ADDR: reg_addr  <= rx_data;
                    GET_DATA: reg_wdata <= rx_data;
                    GET_CHK:  chk_q     <= rx_data;
                    default:  ;
                endcase
            end

            if (state == EXEC) begin
                if (cmd_wr) begin
                    tx_data <= ACK;
                end else if (!cmd_rd) begin
                    tx_data <= NAK;
                end
            end else if (state == RD_WAIT) begin
                tx_data <= reg_rdata;
            end

            if (cnt_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'h01;
            end
        end
    end

endmodule

// File: tb/tb_monitor_cmd_parser.sv
// Directed bench for monitor_cmd_parser: a frame table plus hand-built sequences for
// timeout, error abort, backpressure, reset and err_count saturation.
module tb_monitor_cmd_parser;

    localparam int TO = 40;

    logic       clk50 = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_err = 1'b0;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata = 8'h00;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic [7:0] err_count;

    monitor_cmd_parser #(.TIMEOUT_CYCLES(TO), .SOF_BYTE(8'h7E)) dut (
        .clk50(clk50), .reset_n(reset_n),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .busy(busy), .err_count(err_count)
    );

    always #5 clk50 = ~clk50;

    int checks = 0;
    int fails  = 0;

    // observed activity, sampled on the falling edge
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         tx_cnt = 0;
    logic [7:0] last_addr = 8'h00;
    logic [7:0] last_wdata = 8'h00;
    logic [7:0] last_tx = 8'h00;
    logic       rd_seen = 1'b0;
    logic [7:0] rd_value = 8'h00;

    always @(negedge clk50) begin
        rd_seen = reg_rd_en;
        if (reset_n) begin
            if (reg_wr_en) begin
                wr_cnt++;
                last_addr  = reg_addr;
                last_wdata = reg_wdata;
            end
            if (reg_rd_en) begin
                rd_cnt++;
                last_addr = reg_addr;
            end
            if (tx_valid && tx_ready) begin
                tx_cnt++;
                last_tx = tx_data;
            end
        end
    end

    // read data is meaningful only in the cycle after reg_rd_en
    always @(posedge clk50) begin
        #1;
        reg_rdata = rd_seen ? rd_value : 8'hA5;
    end

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'h01;
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk50); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk50); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [39:0] f);
        for (int i = 0; i < 5; i++) begin
            send_byte(f[39-8*i -: 8]);
        end
    endtask

    task automatic pulse_err(input logic with_valid, input logic [7:0] d);
        @(posedge clk50); #1;
        rx_err   = 1'b1;
        rx_valid = with_valid;
        rx_data  = d;
        @(posedge clk50); #1;
        rx_err   = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk50);
            if (!busy) begin
                found = 1'b1;
                break;
            end
        end
        check8({name, "_idle_timeout"}, {7'd0, found}, 8'h01);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk50);
    endtask

    typedef struct packed {
        logic [39:0] frame;
        logic [7:0]  rdata;
        logic        wr;
        logic        rd;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  tx;
        logic        nak;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] exp_err;
    int         b_wr, b_rd, b_tx;
    logic [7:0] held;
    logic       stable;

    initial begin
        vecs[0] = '{40'h7E0110ABBA, 8'h00, 1'b1, 1'b0, 8'h10, 8'hAB, 8'h06, 1'b0};
        vecs[1] = '{40'h7E02200022, 8'h5C, 1'b0, 1'b1, 8'h20, 8'h00, 8'h5C, 1'b0};
        vecs[2] = '{40'h7E0110AB00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h15, 1'b1};
        vecs[3] = '{40'h7E0310ABB8, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h15, 1'b1};
        vecs[4] = '{40'h7E017E552A, 8'h00, 1'b1, 1'b0, 8'h7E, 8'h55, 8'h06, 1'b0};
        vecs[5] = '{40'h7E02337E4F, 8'hC3, 1'b0, 1'b1, 8'h33, 8'h00, 8'hC3, 1'b0};
        vecs[6] = '{40'h7E00000000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h15, 1'b1};
        vecs[7] = '{40'h7E01FF00FE, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h06, 1'b0};

        // reset values while reset_n is held low
        repeat (3) @(posedge clk50);
        @(negedge clk50);
        check8("rst_wr_en", {7'd0, reg_wr_en}, 8'h00);
        check8("rst_rd_en", {7'd0, reg_rd_en}, 8'h00);
        check8("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
        check8("rst_busy", {7'd0, busy}, 8'h00);
        check8("rst_addr", reg_addr, 8'h00);
        check8("rst_wdata", reg_wdata, 8'h00);
        check8("rst_tx_data", tx_data, 8'h00);
        check8("rst_err_count", err_count, 8'h00);
        @(posedge clk50); #1;
        reset_n = 1'b1;
        exp_err = 8'h00;

        // table of complete frames
        for (int v = 0; v < 8; v++) begin
            b_wr = wr_cnt; b_rd = rd_cnt; b_tx = tx_cnt;
            rd_value = vecs[v].rdata;
            send_frame(vecs[v].frame);
            wait_idle($sformatf("vec%0d", v));
            if (vecs[v].nak) exp_err = sat_inc(exp_err);
            check_int($sformatf("vec%0d_wr", v), wr_cnt - b_wr, int'(vecs[v].wr));
            check_int($sformatf("vec%0d_rd", v), rd_cnt - b_rd, int'(vecs[v].rd));
            if (vecs[v].wr || vecs[v].rd)
                check8($sformatf("vec%0d_addr", v), last_addr, vecs[v].addr);
            if (vecs[v].wr)
                check8($sformatf("vec%0d_wdata", v), last_wdata, vecs[v].wdata);
            check_int($sformatf("vec%0d_tx_cnt", v), tx_cnt - b_tx, 1);
            check8($sformatf("vec%0d_tx_data", v), last_tx, vecs[v].tx);
            check8($sformatf("vec%0d_err", v), err_count, exp_err);
        end

        // non-SOF bytes in IDLE are discarded
        b_wr = wr_cnt; b_tx = tx_cnt;
        send_byte(8'h55);
        send_byte(8'h01);
        send_frame(40'h7E0110ABBA);
        wait_idle("garbage");
        check_int("garbage_wr", wr_cnt - b_wr, 1);
        check_int("garbage_tx", tx_cnt - b_tx, 1);

        // write latency: strobe 1 cycle, tx_valid 2 cycles after CHK
        send_frame(40'h7E0142A7E4);
        @(negedge clk50);
        check8("lat_wr_en", {7'd0, reg_wr_en}, 8'h01);
        check8("lat_wr_addr", reg_addr, 8'h42);
        check8("lat_wr_tx_early", {7'd0, tx_valid}, 8'h00);
        @(negedge clk50);
        check8("lat_wr_tx_valid", {7'd0, tx_valid}, 8'h01);
        check8("lat_wr_tx_data", tx_data, 8'h06);
        wait_idle("lat_wr");

        // read latency: strobe 1 cycle, tx_valid 3 cycles after CHK
        rd_value = 8'h9D;
        send_frame(40'h7E02080208);
        @(negedge clk50);
        check8("lat_rd_en", {7'd0, reg_rd_en}, 8'h01);
        @(negedge clk50);
        check8("lat_rd_tx_early", {7'd0, tx_valid}, 8'h00);
        @(negedge clk50);
        check8("lat_rd_tx_valid", {7'd0, tx_valid}, 8'h01);
        check8("lat_rd_tx_data", tx_data, 8'h9D);
        wait_idle("lat_rd");

        // inter-byte timeout
        b_tx = tx_cnt;
        send_byte(8'h7E);
        send_byte(8'h01);
        idle_cycles(TO - 5);
        check8("to_still_busy", {7'd0, busy}, 8'h01);
        idle_cycles(10);
        exp_err = sat_inc(exp_err);
        check8("to_idle", {7'd0, busy}, 8'h00);
        check_int("to_no_tx", tx_cnt - b_tx, 0);
        check8("to_err", err_count, exp_err);
        b_wr = wr_cnt;
        send_frame(40'h7E0110ABBA);
        wait_idle("to_recover");
        check_int("to_recover_wr", wr_cnt - b_wr, 1);
        check8("to_recover_tx", last_tx, 8'h06);

        // rx_err aborts mid-frame; rx_err beats a coincident rx_valid
        b_tx = tx_cnt;
        send_byte(8'h7E);
        send_byte(8'h01);
        pulse_err(1'b0, 8'h00);
        exp_err = sat_inc(exp_err);
        @(negedge clk50);
        check8("err_abort_idle", {7'd0, busy}, 8'h00);
        check8("err_abort_cnt", err_count, exp_err);
        send_byte(8'h7E);
        send_byte(8'h01);
        pulse_err(1'b1, 8'h10);
        exp_err = sat_inc(exp_err);
        @(negedge clk50);
        check8("err_prio_idle", {7'd0, busy}, 8'h00);
        check8("err_prio_cnt", err_count, exp_err);
        check_int("err_no_tx", tx_cnt - b_tx, 0);

        // rx_err in IDLE is ignored, even with a SOF on the same cycle
        pulse_err(1'b1, 8'h7E);
        @(negedge clk50);
        check8("err_idle_busy", {7'd0, busy}, 8'h00);
        check8("err_idle_cnt", err_count, exp_err);

        // backpressure in RESP; bytes arriving meanwhile are dropped
        tx_ready = 1'b0;
        b_wr = wr_cnt; b_tx = tx_cnt;
        send_frame(40'h7E0110ABBA);
        idle_cycles(2);
        held = tx_data;
        stable = tx_valid;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk50); #1;
            rx_valid = ((i % 4) == 0) && (i < 40);
            rx_data  = (((i / 4) % 5) == 0) ? 8'h7E :
                       (((i / 4) % 5) == 1) ? 8'h01 :
                       (((i / 4) % 5) == 2) ? 8'h10 :
                       (((i / 4) % 5) == 3) ? 8'hAB : 8'hBA;
            @(negedge clk50);
            if (!tx_valid || (tx_data !== held)) stable = 1'b0;
        end
        rx_valid = 1'b0;
        check8("bp_stable", {7'd0, stable}, 8'h01);
        check8("bp_held_data", held, 8'h06);
        tx_ready = 1'b1;
        wait_idle("bp");
        idle_cycles(5);
        check8("bp_stays_idle", {7'd0, busy}, 8'h00);
        check_int("bp_wr", wr_cnt - b_wr, 1);
        check_int("bp_tx", tx_cnt - b_tx, 1);

        // reset mid-frame: later bytes form no frame
        b_wr = wr_cnt; b_tx = tx_cnt;
        send_byte(8'h7E);
        send_byte(8'h01);
        send_byte(8'h10);
        @(posedge clk50); #1; reset_n = 1'b0;
        @(posedge clk50); #1; reset_n = 1'b1;
        exp_err = 8'h00;
        send_byte(8'hAB);
        send_byte(8'hBA);
        idle_cycles(5);
        check_int("rst_frame_wr", wr_cnt - b_wr, 0);
        check_int("rst_frame_tx", tx_cnt - b_tx, 0);
        check8("rst_frame_busy", {7'd0, busy}, 8'h00);
        check8("rst_frame_err", err_count, exp_err);

        // reset in RESP: the held response is abandoned
        tx_ready = 1'b0;
        send_frame(40'h7E0110ABBA);
        idle_cycles(3);
        b_tx = tx_cnt;
        @(posedge clk50); #1; reset_n = 1'b0;
        @(posedge clk50); #1; reset_n = 1'b1;
        tx_ready = 1'b1;
        idle_cycles(5);
        check_int("rst_resp_tx", tx_cnt - b_tx, 0);
        check8("rst_resp_valid", {7'd0, tx_valid}, 8'h00);
        check8("rst_resp_busy", {7'd0, busy}, 8'h00);

        // err_count saturation
        for (int n = 0; n < 300; n++) begin
            send_frame(40'h7E0110AB00);
            wait_idle("sat");
            exp_err = sat_inc(exp_err);
        end
        check8("sat_ff", err_count, 8'hFF);
        send_frame(40'h7E0310ABB8);
        wait_idle("sat_more");
        check8("sat_no_wrap", err_count, 8'hFF);
        check8("sat_model", err_count, exp_err);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
